// File: rtl/hdmi_clk_sup_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_clk_sup_pkg
// Shared definitions for the HDMI TX clock supervisor:
//   - sup_state_t    : supervisor sequencing states
//   - DEF_*          : default parameter values for the supervisor
//   - sup_cnt_width  : width of the shared cycle counter, large enough for
//                      the longest interval the sequencer ever has to time
// ---------------------------------------------------------------------------
package hdmi_clk_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_t;

    localparam int DEF_NUM_DOMAINS        = 2;
    localparam int DEF_PLL_RST_CYCLES     = 16;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_LOCK_TIMEOUT       = 65536;
    localparam int DEF_MAX_RETRIES        = 4;
    localparam int DEF_RST_STAGGER        = 8;
    localparam int DEF_CNT_W              = 8;

    // The one counter is reused for the PLL reset pulse, the lock timeout
    // and the release stagger, so it must hold the largest of the three.
    function automatic int sup_cnt_width(input int lock_timeout,
                                         input int pll_rst_cycles,
                                         input int num_domains,
                                         input int rst_stagger);
        int longest;
        longest = lock_timeout;
        if (pll_rst_cycles > longest)
            longest = pll_rst_cycles;
        if (num_domains * rst_stagger > longest)
            longest = num_domains * rst_stagger;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/hdmi_sync_2ff.sv
// ---------------------------------------------------------------------------
// hdmi_sync_2ff
// Two-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk   in  : destination clock
//   rst_n in  : synchronous active-low reset, both flops clear to 0
//   d     in  : asynchronous input
//   q     out : synchronised output (two clk edges of latency)
// ---------------------------------------------------------------------------
module hdmi_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_tx_clk_supervisor.sv
// ---------------------------------------------------------------------------
// hdmi_tx_clk_supervisor
// PLL lock supervisor and reset sequencer for the HDMI TX clocking path.
// Holds the PLL in reset, waits for a stable qualified lock, releases the
// downstream domain resets one by one, and retries failed locks up to a
// limit before parking in a sticky FAULT state.
//
// Optional feature macro: HDMI_CLK_SUP_LOSS_CNT_EN
//   defined   : loss_count counts lock losses seen in RUN (saturating)
//   undefined : no loss register, loss_count is tied to 0
//
// Ports:
//   refclk         in  : PLL reference clock, all logic on rising edge
//   rst_n          in  : synchronous active-low reset
//   pll_locked_raw in  : raw PLL locked flag (asynchronous)
//   retry_req      in  : one-cycle pulse, restarts the sequence from FAULT
//   pll_rst        out : active-high PLL reset
//   domain_rst_n   out : per-domain active-low resets, bit 0 released first
//   locked         out : high only in RUN
//   fault          out : high only in FAULT
//   retry_count    out : failed lock attempts in the current sequence
//   loss_count     out : saturating count of lock losses in RUN
// ---------------------------------------------------------------------------
module hdmi_tx_clk_supervisor
    import hdmi_clk_sup_pkg::*;
#(
    parameter int NUM_DOMAINS        = DEF_NUM_DOMAINS,
    parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
    parameter int RST_STAGGER        = DEF_RST_STAGGER,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic                             refclk,
    input  logic                             rst_n,
    input  logic                             pll_locked_raw,
    input  logic                             retry_req,
    output logic                             pll_rst,
    output logic [NUM_DOMAINS-1:0]           domain_rst_n,
    output logic                             locked,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [CNT_W-1:0]                 loss_count
);

    localparam int CW = sup_cnt_width(LOCK_TIMEOUT, PLL_RST_CYCLES,
                                      NUM_DOMAINS, RST_STAGGER);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    // Offset (from release entry) at which the last domain is released.
    localparam int REL_LAST = (NUM_DOMAINS - 1) * RST_STAGGER;

    localparam logic [CW-1:0] PRC_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] REL_END     = CW'(REL_LAST);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);

    logic                   lock_s;
    sup_state_t             state_q, state_nxt;
    logic [CW-1:0]          cnt_q, cnt_nxt, cnt_inc;
    logic [CW-1:0]          stable_q, stable_nxt;
    logic [RW-1:0]          retry_q, retry_nxt;
    logic                   pll_rst_nxt;
    logic                   locked_nxt;
    logic                   fault_nxt;
    logic [NUM_DOMAINS-1:0] dom_nxt;

    hdmi_sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked_raw),
        .q     (lock_s)
    );

    assign cnt_inc     = cnt_q + 1'b1;
    assign retry_count = retry_q;

    // State and counter register; outputs are registered from the decode of
    // the next state so they change on the same edge as the state itself.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            stable_q     <= '0;
            retry_q      <= '0;
            pll_rst      <= 1'b1;
            domain_rst_n <= '0;
            locked       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            stable_q     <= stable_nxt;
            retry_q      <= retry_nxt;
            pll_rst      <= pll_rst_nxt;
            domain_rst_n <= dom_nxt;
            locked       <= locked_nxt;
            fault        <= fault_nxt;
        end
    end

    // Next-state and next-output logic.  A failed attempt (timeout or lock
    // drop during release) bumps retry_q; once it has already reached the
    // limit minus one, the failure parks the sequencer in FAULT instead.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        stable_nxt = stable_q;
        retry_nxt  = retry_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == PRC_LAST) begin
                    state_nxt  = WAIT_LOCK;
                    cnt_nxt    = '0;
                    stable_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            WAIT_LOCK: begin
                cnt_nxt    = cnt_inc;
                stable_nxt = lock_s ? (stable_q + 1'b1) : '0;
                // A stable lock beats a timeout landing on the same cycle.
                if (lock_s && (stable_q == STABLE_LAST)) begin
                    cnt_nxt    = '0;
                    stable_nxt = '0;
                    if (REL_LAST == 0) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_nxt    = '0;
                    stable_nxt = '0;
                    retry_nxt  = retry_q + 1'b1;
                    state_nxt  = (retry_q == RETRY_LAST) ? FAULT : PLL_RST;
                end
            end

            RELEASE: begin
                if (!lock_s) begin
                    cnt_nxt   = '0;
                    retry_nxt = retry_q + 1'b1;
                    state_nxt = (retry_q == RETRY_LAST) ? FAULT : PLL_RST;
                end else if (cnt_inc == REL_END) begin
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end

            RUN: begin
                if (!lock_s) begin
                    cnt_nxt   = '0;
                    state_nxt = PLL_RST;
                end
            end

            FAULT: begin
                if (retry_req) begin
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                    state_nxt = PLL_RST;
                end
            end

            default: begin
                state_nxt  = PLL_RST;
                cnt_nxt    = '0;
                stable_nxt = '0;
                retry_nxt  = '0;
            end
        endcase

        pll_rst_nxt = (state_nxt == PLL_RST) || (state_nxt == FAULT);
        locked_nxt  = (state_nxt == RUN);
        fault_nxt   = (state_nxt == FAULT);

        // During release, domain i is out of reset once the release counter
        // has reached i*RST_STAGGER; bit 0 therefore opens on entry.
        dom_nxt = '0;
        if (state_nxt == RUN) begin
            dom_nxt = '1;
        end else if (state_nxt == RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++)
                dom_nxt[i] = (cnt_nxt >= CW'(i * RST_STAGGER));
        end
    end

`ifdef HDMI_CLK_SUP_LOSS_CNT_EN
    logic loss_event;

    assign loss_event = (state_q == RUN) && !lock_s;

    // Lock-loss counter: only losses out of RUN count, and it sticks at
    // all-ones.  A retry from FAULT deliberately leaves it untouched.
    always_ff @(posedge refclk) begin
        if (!rst_n)
            loss_count <= '0;
        else if (loss_event && !(&loss_count))
            loss_count <= loss_count + 1'b1;
    end
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_hdmi_tx_clk_supervisor.sv
// ---------------------------------------------------------------------------
// tb_hdmi_tx_clk_supervisor
// Self-checking bench for hdmi_tx_clk_supervisor with small parameters.
// A behavioural model tracks the phase of the sequence and the time spent
// in it; expected outputs are derived from that phase each cycle.
// ---------------------------------------------------------------------------
module tb_hdmi_tx_clk_supervisor;

    localparam int ND   = 3;
    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int LT   = 32;
    localparam int MR   = 2;
    localparam int RS   = 3;
    localparam int LW   = 8;
    localparam int RW   = $clog2(MR + 1);
    localparam int LMAX = (1 << LW) - 1;

    localparam int PH_RST  = 10;
    localparam int PH_WAIT = 11;
    localparam int PH_REL  = 12;
    localparam int PH_RUN  = 13;
    localparam int PH_FLT  = 14;

    logic          refclk = 1'b0;
    logic          rst_n;
    logic          pll_locked_raw;
    logic          retry_req;
    logic          pll_rst;
    logic [ND-1:0] domain_rst_n;
    logic          locked;
    logic          fault;
    logic [RW-1:0] retry_count;
    logic [LW-1:0] loss_count;

    int checks = 0;
    int passes = 0;

    int m_phase    = PH_RST;
    int m_elapsed  = 0;
    int m_good     = 0;
    int m_attempts = 0;
    int m_losses   = 0;
    bit m_s1       = 1'b0;
    bit m_s2       = 1'b0;

    hdmi_tx_clk_supervisor #(
        .NUM_DOMAINS        (ND),
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT       (LT),
        .MAX_RETRIES        (MR),
        .RST_STAGGER        (RS),
        .CNT_W              (LW)
    ) dut (
        .refclk         (refclk),
        .rst_n          (rst_n),
        .pll_locked_raw (pll_locked_raw),
        .retry_req      (retry_req),
        .pll_rst        (pll_rst),
        .domain_rst_n   (domain_rst_n),
        .locked         (locked),
        .fault          (fault),
        .retry_count    (retry_count),
        .loss_count     (loss_count)
    );

    always #5 refclk = ~refclk;

    // A failed lock attempt either retries or gives up for good.
    task automatic modelFail();
        m_attempts++;
        m_elapsed = 0;
        m_good    = 0;
        m_phase   = (m_attempts == MR) ? PH_FLT : PH_RST;
    endtask

    // One rising edge of the reference model.
    task automatic modelStep(input bit raw, input bit rr, input bit rstn);
        bit ls;
        if (!rstn) begin
            m_phase    = PH_RST;
            m_elapsed  = 0;
            m_good     = 0;
            m_attempts = 0;
            m_losses   = 0;
            m_s1       = 1'b0;
            m_s2       = 1'b0;
            return;
        end
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        case (m_phase)
            PH_RST: begin
                m_elapsed++;
                if (m_elapsed == PRC) begin
                    m_phase   = PH_WAIT;
                    m_elapsed = 0;
                    m_good    = 0;
                end
            end
            PH_WAIT: begin
                m_good = ls ? m_good + 1 : 0;
                m_elapsed++;
                if (m_good == LSC) begin
                    m_phase   = PH_REL;
                    m_elapsed = 0;
                    m_good    = 0;
                end else if (m_elapsed == LT) begin
                    modelFail();
                end
            end
            PH_REL: begin
                if (!ls) begin
                    modelFail();
                end else begin
                    m_elapsed++;
                    if (m_elapsed == (ND - 1) * RS) begin
                        m_phase    = PH_RUN;
                        m_elapsed  = 0;
                        m_attempts = 0;
                    end
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    if (m_losses < LMAX)
                        m_losses++;
                    m_phase   = PH_RST;
                    m_elapsed = 0;
                end
            end
            default: begin
                if (rr) begin
                    m_phase    = PH_RST;
                    m_elapsed  = 0;
                    m_attempts = 0;
                end
            end
        endcase
    endtask

    function automatic logic [ND-1:0] expDom();
        if (m_phase == PH_RUN)
            return ND'((1 << ND) - 1);
        if (m_phase == PH_REL)
            return ND'((1 << (m_elapsed / RS + 1)) - 1);
        return '0;
    endfunction

    function automatic int expLoss();
`ifdef HDMI_CLK_SUP_LOSS_CNT_EN
        return m_losses;
`else
        return 0;
`endif
    endfunction

    task automatic checkOne(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic checkOutput();
        checkOne("pll_rst",      32'(pll_rst),      32'(m_phase == PH_RST || m_phase == PH_FLT));
        checkOne("domain_rst_n", 32'(domain_rst_n), 32'(expDom()));
        checkOne("locked",       32'(locked),       32'(m_phase == PH_RUN));
        checkOne("fault",        32'(fault),        32'(m_phase == PH_FLT));
        checkOne("retry_count",  32'(retry_count),  32'(m_attempts));
        checkOne("loss_count",   32'(loss_count),   32'(expLoss()));
    endtask

    // Drive inputs away from the edge, step DUT and model, check at negedge.
    task automatic applyStimulus(input bit raw, input bit rr, input bit rstn);
        pll_locked_raw = raw;
        retry_req      = rr;
        rst_n          = rstn;
        @(posedge refclk);
        modelStep(raw, rr, rstn);
        @(negedge refclk);
        checkOutput();
    endtask

    initial begin
        int n;
        bit raw;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOne("rst_pll_rst", 32'(pll_rst), 32'd1);
        checkOne("rst_domains", 32'(domain_rst_n), 32'd0);

        $display("[TB] clean lock");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        n = 0;
        while (locked !== 1'b1 && n < 100) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end
        checkOne("clean_locked", 32'(locked), 32'd1);
        checkOne("clean_domains", 32'(domain_rst_n), 32'h7);

        $display("[TB] lock loss in RUN");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOne("loss_domains", 32'(domain_rst_n), 32'd0);
        checkOne("loss_locked", 32'(locked), 32'd0);
        checkOne("loss_pll_rst", 32'(pll_rst), 32'd1);
`ifdef HDMI_CLK_SUP_LOSS_CNT_EN
        checkOne("loss_count1", 32'(loss_count), 32'd1);
`else
        checkOne("loss_count0", 32'(loss_count), 32'd0);
`endif

        $display("[TB] glitchy lock");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        n = 0;
        while (locked !== 1'b1 && n < 60) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end
        checkOne("glitch_locked", 32'(locked), 32'd1);

        $display("[TB] timeout and fault");
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end
        checkOne("fault_set", 32'(fault), 32'd1);
        checkOne("fault_pll_rst", 32'(pll_rst), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOne("retry_fault", 32'(fault), 32'd0);
        checkOne("retry_count0", 32'(retry_count), 32'd0);
        checkOne("retry_pll_rst", 32'(pll_rst), 32'd1);

        $display("[TB] loss mid-release");
        n = 0;
        while (domain_rst_n !== 3'b011 && n < 100) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end
        checkOne("midrel_reach", 32'(domain_rst_n), 32'h3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOne("midrel_domains", 32'(domain_rst_n), 32'd0);
        checkOne("midrel_retry", 32'(retry_count), 32'd1);

        $display("[TB] reset mid-RUN");
        n = 0;
        while (locked !== 1'b1 && n < 100) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end
        checkOne("prerst_locked", 32'(locked), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOne("midrst_pll_rst", 32'(pll_rst), 32'd1);
        checkOne("midrst_domains", 32'(domain_rst_n), 32'd0);
        checkOne("midrst_locked", 32'(locked), 32'd0);
        checkOne("midrst_loss", 32'(loss_count), 32'd0);

        $display("[TB] randomized traffic");
        raw = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 4)
                raw = ~raw;
            applyStimulus(raw, ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 399) != 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
